// File: rtl/i2s_pkg.sv
// Shared framing constants and frame-length helper for the stereo I2S transmitter.
package i2s_pkg;

  localparam int MODE_I2S = 0;
  localparam int MODE_LJ  = 1;

  function automatic int frame_len(input int slot_w);
    return 2 * slot_w;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: bclk toggles every CLK_DIV clk while run_i is high, parked low otherwise.
// Ticks are combinational and coincide with the clk edge on which bclk changes.
module i2s_bclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic bclk_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bclk_q, bclk_d;
  logic          tc;

  assign tc          = run_i && (cnt_q == TC);
  assign rise_tick_o = tc && !bclk_q;
  assign fall_tick_o = tc && bclk_q;
  assign bclk_o      = bclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    bclk_d = bclk_q;
    if (!run_i) begin
      cnt_d  = '0;
      bclk_d = 1'b0;
    end else if (tc) begin
      cnt_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

endmodule

// File: rtl/i2s_tx_stereo.sv
// Stereo I2S / left-justified serialiser with a one-deep sample holding register.
// A held pair reaches dataout at the next frame boundary; sample_ready is low while the holder is full.
module i2s_tx_stereo
  import i2s_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SLOT_W  = 16,
  parameter int CLK_DIV = 4,
  parameter int MODE    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] left_data,
  input  logic [DATA_W-1:0] right_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              bclk,
  output logic              lrclk,
  output logic              dataout,
  output logic              done,
  output logic              underrun
);

  localparam int FL = frame_len(SLOT_W);
  localparam int BW = $clog2(FL);
  localparam logic [BW-1:0] LAST_BIT     = BW'(FL - 1);
  localparam logic [BW-1:0] PRE_LAST_BIT = BW'(FL - 2);
  localparam logic [BW-1:0] SLOT_BIT     = BW'(SLOT_W);
  localparam logic [BW-1:0] PRE_SLOT_BIT = BW'(SLOT_W - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [FL-1:0]       sh_q, sh_d, frame_word;
  logic [2*DATA_W-1:0] hold_q, hold_d;
  logic                full_q, full_d;
  logic                lr_q, lr_d;
  logic                done_q, done_d;
  logic                und_q, und_d;
  logic                fall_tick, rise_tick_unused, bclk_w;
  logic                take, load;

  i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk_gen (
    .clk_i       (clk),
    .rst_i       (reset),
    .run_i       (state_q == ST_RUN),
    .bclk_o      (bclk_w),
    .rise_tick_o (rise_tick_unused),
    .fall_tick_o (fall_tick)
  );

  assign take = sample_valid && !full_q;

  // Each channel occupies the top DATA_W bits of its slot; the tail is zero.
  always_comb begin
    frame_word = '0;
    frame_word[FL-1 -: DATA_W]     = hold_q[2*DATA_W-1 -: DATA_W];
    frame_word[SLOT_W-1 -: DATA_W] = hold_q[DATA_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    hold_d  = hold_q;
    full_d  = full_q;
    done_d  = 1'b0;
    und_d   = 1'b0;
    load    = 1'b0;
    lr_d    = 1'b0;

    if (state_q == ST_IDLE) begin
      if (enable) begin
        state_d = ST_RUN;
        bit_d   = '0;
        load    = 1'b1;
      end
    end else if (fall_tick) begin
      if (bit_q == LAST_BIT) begin
        done_d = 1'b1;
        bit_d  = '0;
        if (enable) begin
          load = 1'b1;
        end else begin
          state_d = ST_IDLE;
          sh_d    = '0;
        end
      end else begin
        bit_d = bit_q + BW'(1);
        sh_d  = sh_q << 1;
      end
    end

    // The frame takes the old pair; a same-cycle transfer refills the holder.
    if (load) begin
      sh_d   = full_q ? frame_word : '0;
      und_d  = !full_q;
      full_d = 1'b0;
    end
    if (take) begin
      hold_d = {left_data, right_data};
      full_d = 1'b1;
    end

    // I2S moves the channel edge one bit ahead of the slot it announces.
    if (state_d == ST_RUN) begin
      if (MODE == MODE_LJ) lr_d = (bit_d >= SLOT_BIT);
      else                 lr_d = (bit_d >= PRE_SLOT_BIT) && (bit_d <= PRE_LAST_BIT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      sh_q    <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      lr_q    <= 1'b0;
      done_q  <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      lr_q    <= lr_d;
      done_q  <= done_d;
      und_q   <= und_d;
    end
  end

  assign sample_ready = ~full_q;
  assign bclk         = bclk_w;
  assign lrclk        = lr_q;
  assign dataout      = sh_q[FL-1];
  assign done         = done_q;
  assign underrun     = und_q;

endmodule

// File: tb/tb_i2s_tx_stereo.sv
// Bench for i2s_tx_stereo: a left-justified 16/16 instance and an I2S 24/32 instance share timing and stimulus.
module tb_i2s_tx_stereo;

  localparam int DW_A = 16, SW_A = 16, CD_A = 4;
  localparam int DW_B = 24, SW_B = 32, CD_B = 2;
  localparam int FL_B = 2 * SW_B;
  localparam int FRAME_CLK = 2 * SW_A * 2 * CD_A;

  logic clk = 1'b0;
  logic reset;
  logic enable = 1'b0;
  logic sample_valid = 1'b0;
  logic [15:0] la = '0, ra = '0;
  logic [23:0] lb = '0, rb = '0;

  logic ready_a, bclk_a, lrclk_a, dout_a, done_a, und_a;
  logic ready_b, bclk_b, lrclk_b, dout_b, done_b, und_b;

  always #5 clk = ~clk;

  i2s_tx_stereo #(.DATA_W(DW_A), .SLOT_W(SW_A), .CLK_DIV(CD_A), .MODE(1)) u_lj (
    .clk(clk), .reset(reset), .enable(enable), .left_data(la), .right_data(ra),
    .sample_valid(sample_valid), .sample_ready(ready_a), .bclk(bclk_a), .lrclk(lrclk_a),
    .dataout(dout_a), .done(done_a), .underrun(und_a));

  i2s_tx_stereo #(.DATA_W(DW_B), .SLOT_W(SW_B), .CLK_DIV(CD_B), .MODE(0)) u_i2s (
    .clk(clk), .reset(reset), .enable(enable), .left_data(lb), .right_data(rb),
    .sample_valid(sample_valid), .sample_ready(ready_b), .bclk(bclk_b), .lrclk(lrclk_b),
    .dataout(dout_b), .done(done_b), .underrun(und_b));

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: frames are fixed 256-clk windows counted from the enable edge.
  logic        m_run = 1'b0, m_full = 1'b0, m_done = 1'b0, m_und = 1'b0, m_acc = 1'b0;
  int          m_t = 0;
  logic [15:0] h_la = '0, h_ra = '0, c_la = '0, c_ra = '0;
  logic [23:0] h_lb = '0, h_rb = '0, c_lb = '0, c_rb = '0;
  logic        m_start, m_end, m_load, m_accept;

  assign m_start  = !m_run && enable;
  assign m_end    = m_run && (m_t == FRAME_CLK - 1);
  assign m_load   = m_start || (m_end && enable);
  assign m_accept = sample_valid && !m_full;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run <= 1'b0; m_t <= 0; m_full <= 1'b0; m_done <= 1'b0; m_und <= 1'b0; m_acc <= 1'b0;
      c_la <= '0; c_ra <= '0; c_lb <= '0; c_rb <= '0;
    end else begin
      if (m_start) m_run <= 1'b1;
      else if (m_end && !enable) m_run <= 1'b0;
      m_t    <= (m_start || m_end || !m_run) ? 0 : m_t + 1;
      m_done <= m_end;
      m_und  <= m_load && !m_full;
      if (m_load) begin
        c_la <= m_full ? h_la : '0; c_ra <= m_full ? h_ra : '0;
        c_lb <= m_full ? h_lb : '0; c_rb <= m_full ? h_rb : '0;
      end
      m_full <= m_accept ? 1'b1 : (m_load ? 1'b0 : m_full);
      if (m_accept) begin
        h_la <= la; h_ra <= ra; h_lb <= lb; h_rb <= rb;
      end
      m_acc <= m_accept;
    end
  end

  function automatic logic slot_bit(input logic [31:0] l, input logic [31:0] r,
                                    input int dw, input int sw, input int k);
    int pos = k % sw;
    logic [31:0] s = (k < sw) ? l : r;
    if (pos >= dw) return 1'b0;
    return s[dw-1-pos];
  endfunction

  function automatic logic exp_bclk(input int cd);
    return m_run && (((m_t / cd) % 2) == 1);
  endfunction

  always @(negedge clk) begin
    chk("bclk_a", bclk_a, exp_bclk(CD_A));
    chk("bclk_b", bclk_b, exp_bclk(CD_B));
    chk("lrclk_a", lrclk_a, m_run && ((m_t / (2 * CD_A)) >= SW_A));
    chk("lrclk_b", lrclk_b, m_run && ((((m_t / (2 * CD_B)) + 1) % FL_B) >= SW_B));
    chk("dout_a", dout_a, m_run && slot_bit(32'(c_la), 32'(c_ra), DW_A, SW_A, m_t / (2 * CD_A)));
    chk("dout_b", dout_b, m_run && slot_bit(32'(c_lb), 32'(c_rb), DW_B, SW_B, m_t / (2 * CD_B)));
    chk("done_a", done_a, m_done);
    chk("done_b", done_b, m_done);
    chk("underrun_a", und_a, m_und);
    chk("underrun_b", und_b, m_und);
    chk("ready_a", ready_a, !m_full);
    chk("ready_b", ready_b, !m_full);
  end

  task automatic send_pair(input logic [15:0] a_l, input logic [15:0] a_r,
                           input logic [23:0] b_l, input logic [23:0] b_r);
    @(negedge clk);
    la = a_l; ra = a_r; lb = b_l; rb = b_r;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Collects (dataout, lrclk) at every bclk rising edge, MSB first, and counts done pulses.
  task automatic capture(input int n, output logic [63:0] cap_a, output logic [63:0] lrc_a,
                         output logic [63:0] cap_b, output logic [63:0] lrc_b, output int nd);
    logic pa, pb;
    cap_a = '0; lrc_a = '0; cap_b = '0; lrc_b = '0; nd = 0;
    pa = bclk_a; pb = bclk_b;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bclk_a && !pa) begin
        cap_a = {cap_a[62:0], dout_a}; lrc_a = {lrc_a[62:0], lrclk_a};
      end
      if (bclk_b && !pb) begin
        cap_b = {cap_b[62:0], dout_b}; lrc_b = {lrc_b[62:0], lrclk_b};
      end
      pa = bclk_a; pb = bclk_b;
      if (done_a) nd++;
    end
  endtask

  initial begin
    logic [63:0] ca, lra, cb, lrb;
    int nd, cnt, exp_und;
    logic found;
    logic [15:0] e_la, e_ra;
    logic [23:0] e_lb, e_rb;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {ready_a, ready_b}, 2'b11);
    chk("rst_outs", {bclk_a, lrclk_a, dout_a, done_a, und_a, bclk_b, lrclk_b, dout_b}, 8'h00);
    reset = 1'b0;

    send_pair(16'hA5F0, 16'h0F0F, 24'h123456, 24'hFEDCBA);
    enable = 1'b1;
    capture(FRAME_CLK + 1, ca, lra, cb, lrb, nd);
    chk("lj_bits", ca, 64'h0000_0000_A5F0_0F0F);
    chk("lj_lrclk", lra, 64'h0000_0000_0000_FFFF);
    chk("i2s_bits", cb, 64'h1234_5600_FEDC_BA00);
    chk("i2s_lrclk", lrb, 64'h0000_0001_FFFF_FFFE);
    chk("first_done", nd, 1);

    // Source always valid: the holder refills right after each frame load.
    la = 16'($urandom); ra = 16'($urandom); lb = 24'($urandom); rb = 24'($urandom);
    sample_valid = 1'b1;
    for (int i = 0; i < 4 * FRAME_CLK; i++) begin
      @(negedge clk);
      if (m_acc) begin
        la = 16'($urandom); ra = 16'($urandom); lb = 24'($urandom); rb = 24'($urandom);
      end
    end

    // Source stops: the held pair drains, then every frame is an underrun.
    sample_valid = 1'b0;
    exp_und = m_full ? 2 : 3;
    cnt = 0;
    for (int i = 0; i < 3 * FRAME_CLK; i++) begin
      @(negedge clk);
      if (und_a) cnt++;
    end
    chk("underrun_cnt", cnt, exp_und);

    // Sparse random source mixing data frames and underruns.
    for (int i = 0; i < 6 * FRAME_CLK; i++) begin
      @(negedge clk);
      if (!sample_valid || m_acc) begin
        sample_valid = ($urandom_range(0, 199) == 0);
        la = 16'($urandom); ra = 16'($urandom); lb = 24'($urandom); rb = 24'($urandom);
      end
    end
    sample_valid = 1'b0;

    found = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLK && !found; i++) begin
      @(negedge clk);
      if (m_run && m_t == 5 * 2 * CD_A) found = 1'b1;
    end
    chk("find_bit5", found, 1'b1);
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < FRAME_CLK + 40; i++) begin
      @(negedge clk);
      if (done_a) cnt++;
    end
    chk("stop_done", cnt, 1);
    chk("idle_bclk", {bclk_a, bclk_b}, 2'b00);

    if (!m_full) send_pair(16'($urandom), 16'($urandom), 24'($urandom), 24'($urandom));
    e_la = h_la; e_ra = h_ra; e_lb = h_lb; e_rb = h_rb;
    enable = 1'b1;
    capture(FRAME_CLK + 1, ca, lra, cb, lrb, nd);
    chk("restart_bits_a", ca, {32'h0, e_la, e_ra});
    chk("restart_bits_b", cb, {e_lb, 8'h00, e_rb, 8'h00});
    chk("restart_done", nd, 1);

    // Asynchronous reset in the middle of a frame.
    repeat (70) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_outs", {bclk_a, lrclk_a, dout_a, done_a, und_a, bclk_b, lrclk_b, dout_b, done_b, und_b}, 10'h000);
    chk("mid_rst_ready", {ready_a, ready_b}, 2'b11);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
